// File: rtl/branch_target_predictor.sv
// IF-stage branch predictor: tagged BTB plus 2-bit saturating PHT (bimodal or gshare),
// combinational lookup, EX-side training, and saturating branch/mispredict statistics.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 64,
    parameter int TAG_W   = 8,
    parameter int GHR_W   = 4,
    parameter int MODE    = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            update_valid,
    input  logic [PC_W-1:0] update_pc,
    input  logic            update_taken,
    input  logic [PC_W-1:0] update_target,
    input  logic            update_mispredict,
    input  logic            stats_clear,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;

    logic [IDX_W-1:0] lk_bidx, lk_pidx, up_bidx, up_pidx, ghr_ext;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [31:0]      branch_count_q, branch_count_d;
    logic [31:0]      mispredict_count_q, mispredict_count_d;

    logic             btb_valid    [ENTRIES];
    logic [1:0]       pht          [ENTRIES];
    logic [TAG_W-1:0] btb_tag_q    [ENTRIES];
    logic [PC_W-1:0]  btb_target_q [ENTRIES];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], lookup_pc[PC_W-1:TAG_LO+TAG_W],
                              update_pc[1:0], update_pc[PC_W-1:TAG_LO+TAG_W]};

    assign ghr_ext = IDX_W'(ghr_q);
    assign lk_bidx = lookup_pc[IDX_W+1:2];
    assign up_bidx = update_pc[IDX_W+1:2];
    assign lk_tag  = lookup_pc[TAG_LO+TAG_W-1:TAG_LO];
    assign up_tag  = update_pc[TAG_LO+TAG_W-1:TAG_LO];
    // Both sides use the pre-edge history, so lookups and updates agree on the slot.
    assign lk_pidx = (MODE == 1) ? (lk_bidx ^ ghr_ext) : lk_bidx;
    assign up_pidx = (MODE == 1) ? (up_bidx ^ ghr_ext) : up_bidx;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic       valid_q, valid_d;
            logic [1:0] pht_q, pht_d;

            always_comb begin
                valid_d = valid_q;
                pht_d   = pht_q;
                if (update_valid) begin
                    if (update_taken && (up_bidx == IDX_W'(gi))) begin
                        valid_d = 1'b1;
                    end
                    if (up_pidx == IDX_W'(gi)) begin
                        if (update_taken) begin
                            if (pht_q != 2'b11) pht_d = pht_q + 2'd1;
                        end else if (pht_q != 2'b00) begin
                            pht_d = pht_q - 2'd1;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_q <= 1'b0;
                    pht_q   <= 2'b01;
                end else begin
                    valid_q <= valid_d;
                    pht_q   <= pht_d;
                end
            end

            assign btb_valid[gi] = valid_q;
            assign pht[gi]       = pht_q;
        end
    endgenerate

    // Tag/target payload needs no reset: the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (update_valid && update_taken) begin
            btb_tag_q[up_bidx]    <= up_tag;
            btb_target_q[up_bidx] <= update_target;
        end
    end

    always_comb begin
        ghr_d              = ghr_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (update_valid) begin
            ghr_d = GHR_W'({ghr_q, update_taken});
        end
        if (stats_clear) begin
            branch_count_d     = '0;
            mispredict_count_d = '0;
        end else if (update_valid) begin
            if (branch_count_q != 32'hFFFF_FFFF) branch_count_d = branch_count_q + 32'd1;
            if (update_mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q              <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            ghr_q              <= ghr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign pred_hit         = btb_valid[lk_bidx] && (btb_tag_q[lk_bidx] == lk_tag);
    assign pred_taken       = pred_hit && pht[lk_pidx][1];
    assign pred_target      = pred_taken ? btb_target_q[lk_bidx] : lookup_pc + PC_W'(4);
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: bimodal and gshare instances driven in parallel,
// checked against a table-level model (directed test-plan steps, then random traffic).
module tb_branch_target_predictor;
    localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] lookup_pc = 64'h40;
    logic        update_valid = 1'b0;
    logic [63:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [63:0] update_target = '0;
    logic        update_mispredict = 1'b0;
    logic        stats_clear = 1'b0;

    logic        hit0, tk0, hit1, tk1;
    logic [63:0] tg0, tg1;
    logic [31:0] bc0, mc0, bc1, mc1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          mvalid [16];
    int          mtag   [16];
    logic [63:0] mtgt   [16];
    int          pht0   [16];
    int          pht1   [16];
    int          ghr;
    longint      bc, mc;

    always #5 clk = ~clk;

    branch_target_predictor #(.MODE(0)) dut0 (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(hit0), .pred_taken(tk0), .pred_target(tg0),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .stats_clear(stats_clear), .branch_count(bc0), .mispredict_count(mc0));

    branch_target_predictor #(.MODE(1)) dut1 (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(hit1), .pred_taken(tk1), .pred_target(tg1),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .stats_clear(stats_clear), .branch_count(bc1), .mispredict_count(mc1));

    function automatic int fidx(logic [63:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int ftag(logic [63:0] pc);
        return int'((pc / 64) % 256);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mvalid[i] = 1'b0;
            pht0[i]   = 1;
            pht1[i]   = 1;
        end
        ghr = 0;
        bc  = 0;
        mc  = 0;
    endtask

    task automatic model_update(bit upv, logic [63:0] pc, bit tk, logic [63:0] tgt,
                                bit mis, bit clr);
        int i;
        int p;
        if (clr) begin
            bc = 0;
            mc = 0;
        end else if (upv) begin
            if (bc < MAXC) bc++;
            if (mis && mc < MAXC) mc++;
        end
        if (upv) begin
            i = fidx(pc);
            p = i ^ ghr;
            if (tk) begin
                pht0[i]   = (pht0[i] == 3) ? 3 : pht0[i] + 1;
                pht1[p]   = (pht1[p] == 3) ? 3 : pht1[p] + 1;
                mvalid[i] = 1'b1;
                mtag[i]   = ftag(pc);
                mtgt[i]   = tgt;
            end else begin
                pht0[i] = (pht0[i] == 0) ? 0 : pht0[i] - 1;
                pht1[p] = (pht1[p] == 0) ? 0 : pht1[p] - 1;
            end
            ghr = (ghr * 2 + int'(tk)) % 16;
        end
    endtask

    task automatic check_lookup(logic [63:0] lpc);
        int i;
        bit h, t0, t1;
        i  = fidx(lpc);
        h  = mvalid[i] && (mtag[i] == ftag(lpc));
        t0 = h && (pht0[i] >= 2);
        t1 = h && (pht1[i ^ ghr] >= 2);
        chk($sformatf("hit0@%0h", lpc), 64'(hit0), 64'(h));
        chk($sformatf("taken0@%0h", lpc), 64'(tk0), 64'(t0));
        chk($sformatf("target0@%0h", lpc), tg0, t0 ? mtgt[i] : lpc + 64'd4);
        chk($sformatf("hit1@%0h", lpc), 64'(hit1), 64'(h));
        chk($sformatf("taken1@%0h", lpc), 64'(tk1), 64'(t1));
        chk($sformatf("target1@%0h", lpc), tg1, t1 ? mtgt[i] : lpc + 64'd4);
    endtask

    task automatic check_counts();
        chk("branch_count0", 64'(bc0), 64'(bc));
        chk("mispredict_count0", 64'(mc0), 64'(mc));
        chk("branch_count1", 64'(bc1), 64'(bc));
        chk("mispredict_count1", 64'(mc1), 64'(mc));
    endtask

    // One cycle, starting and ending at a falling edge. Lookup is checked before the
    // edge (so a same-cycle update must not be visible yet), counts after it.
    task automatic step(bit upv, logic [63:0] pc, bit tk, logic [63:0] tgt, bit mis,
                        bit clr, logic [63:0] lpc);
        update_valid      = upv;
        update_pc         = pc;
        update_taken      = tk;
        update_target     = tgt;
        update_mispredict = mis;
        stats_clear       = clr;
        lookup_pc         = lpc;
        #1;
        check_lookup(lpc);
        @(posedge clk);
        model_update(upv, pc, tk, tgt, mis, clr);
        @(negedge clk);
        update_valid = 1'b0;
        stats_clear  = 1'b0;
        check_counts();
    endtask

    task automatic upd(logic [63:0] pc, bit tk, logic [63:0] tgt, bit mis);
        step(1'b1, pc, tk, tgt, mis, 1'b0, pc);
    endtask

    task automatic look(logic [63:0] lpc);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, lpc);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] pc, lpc, tgt;
        model_reset();
        // Power-up reset held across clock edges
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_hit", 64'(hit0), 64'h0);
        chk("rst_taken", 64'(tk0), 64'h0);
        chk("rst_target", tg0, 64'h44);
        chk("rst_count", 64'(bc0), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        look(64'h40);

        // Bimodal training
        upd(64'h100, 1'b1, 64'h80, 1'b0);
        look(64'h100);
        chk("bim_hit", 64'(hit0), 64'h1);
        chk("bim_taken", 64'(tk0), 64'h1);
        chk("bim_target", tg0, 64'h80);
        upd(64'h100, 1'b0, 64'h0, 1'b0);
        look(64'h100);
        chk("bim_nt_hit", 64'(hit0), 64'h1);
        chk("bim_nt_taken", 64'(tk0), 64'h0);
        chk("bim_nt_target", tg0, 64'h104);

        // Saturation at both ends
        for (int i = 0; i < 3; i++) upd(64'h100, 1'b1, 64'h80, 1'b0);
        upd(64'h100, 1'b0, 64'h0, 1'b0);
        look(64'h100);
        chk("sat_hi_taken", 64'(tk0), 64'h1);
        for (int i = 0; i < 4; i++) upd(64'h100, 1'b0, 64'h0, 1'b0);
        upd(64'h100, 1'b1, 64'h80, 1'b0);
        look(64'h100);
        chk("sat_lo_taken", 64'(tk0), 64'h0);

        // Aliasing between 0x100 and 0x500
        upd(64'h100, 1'b1, 64'h80, 1'b0);
        look(64'h500);
        chk("alias_hit", 64'(hit0), 64'h0);
        chk("alias_target", tg0, 64'h504);
        upd(64'h500, 1'b1, 64'h200, 1'b0);
        look(64'h100);
        chk("alias_evict_hit", 64'(hit0), 64'h0);

        // Gshare from a clean history
        reset_pulse();
        upd(64'h200, 1'b1, 64'h300, 1'b0);
        upd(64'h204, 1'b1, 64'h304, 1'b0);
        upd(64'h208, 1'b1, 64'h308, 1'b0);
        upd(64'h100, 1'b1, 64'h180, 1'b0);
        look(64'h100);
        chk("gshare_hit", 64'(hit1), 64'h1);
        chk("gshare_taken", 64'(tk1), 64'h0);
        chk("gshare_target", tg1, 64'h104);

        // Statistics
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h40);
        for (int i = 1; i <= 5; i++) upd(64'h300 + 64'(i * 4), i[0], 64'h900, (i == 2) || (i == 4));
        chk("stats_branches", 64'(bc0), 64'd5);
        chk("stats_mispredicts", 64'(mc0), 64'd2);
        step(1'b1, 64'h100, 1'b1, 64'h180, 1'b1, 1'b1, 64'h100);
        chk("clear_branches", 64'(bc0), 64'd0);
        chk("clear_mispredicts", 64'(mc0), 64'd0);
        look(64'h100);

        // Random traffic with aliasing tags and same-cycle lookup/update
        for (int n = 0; n < 300; n++) begin
            pc  = 64'($urandom_range(0, 2) * 64 + $urandom_range(0, 15) * 4
                      + $urandom_range(0, 1) * 32'h0010_0000);
            lpc = ($urandom_range(0, 1) == 1) ? pc
                : 64'($urandom_range(0, 2) * 64 + $urandom_range(0, 15) * 4);
            tgt = {$urandom, $urandom} & ~64'h3;
            step($urandom_range(0, 3) != 0, pc, 1'($urandom), tgt, 1'($urandom),
                 $urandom_range(0, 15) == 0, lpc);
        end

        // Counter saturation at all-ones
        force dut0.branch_count_q = 32'hFFFF_FFFF;
        force dut1.branch_count_q = 32'hFFFF_FFFF;
        bc = MAXC;
        upd(64'h104, 1'b1, 64'h500, 1'b0);
        release dut0.branch_count_q;
        release dut1.branch_count_q;
        upd(64'h108, 1'b0, 64'h0, 1'b0);
        chk("sat_branch_count", 64'(bc0), 64'hFFFF_FFFF);

        // Asynchronous reset in the middle of an update cycle
        update_valid  = 1'b1;
        update_pc     = 64'h100;
        update_taken  = 1'b1;
        update_target = 64'h777;
        lookup_pc     = 64'h40;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_hit", 64'(hit0), 64'h0);
        chk("async_rst_taken", 64'(tk0), 64'h0);
        chk("async_rst_target", tg0, 64'h44);
        chk("async_rst_count", 64'(bc0), 64'h0);
        chk("async_rst_count1", 64'(bc1), 64'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        update_valid = 1'b0;
        rst = 1'b1;
        check_counts();
        look(64'h100);
        look(64'h500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
